// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache <-> main memory interface.
// Address field positions are reused by cache_controller.
package mem_if_pkg;

  localparam int unsigned WORD_SIZE  = 32;
  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned OFFSET_MSB = 1;
  localparam int unsigned INDEX_LSB  = 2;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/mem_store_array.sv
// Single-port synchronous RAM with registered read and no reset.
// Kept separate so it can be swapped for a vendor macro.
module mem_store_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/main_memory_responder.sv
// Main memory responder: word-addressed backing store answering cache
// read/write strobes after a fixed LATENCY with a one-cycle mem_ready pulse.
module main_memory_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned WORD_SIZE = mem_if_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          mem_address,
  input  logic [WORD_SIZE-1:0] mem_data_in,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_data_out,
  output logic                 mem_ready,
  output logic                 mem_busy,
  output logic                 protocol_err
);
  import mem_if_pkg::*;

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  op_t                  op_q, op_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic                 err_q, err_d;

  logic [IW-1:0]        idx_in;
  logic [IW-1:0]        ram_addr;
  logic                 ram_we;
  logic [WORD_SIZE-1:0] ram_q;
  logic                 complete;
  logic                 unused_addr;

  assign idx_in      = mem_address[INDEX_LSB +: IW];
  assign unused_addr = ^{mem_address[31:INDEX_LSB+IW], mem_address[OFFSET_MSB:OFFSET_LSB]};
  assign complete    = (state_q == BUSY) && (cnt_q == '0);

  // The RAM looks at the incoming index while idle so a read accepted at this
  // edge has its data ready in the next cycle, which is what LATENCY=1 needs.
  assign ram_addr = (state_q == IDLE) ? idx_in : idx_q;
  assign ram_we   = complete && (op_q == OP_WRITE);

  mem_store_array #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_SIZE)
  ) u_store (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    hold_d  = hold_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          idx_d   = idx_in;
          wdata_d = mem_data_in;
          op_d    = mem_write ? OP_WRITE : OP_READ;
          err_d   = mem_read && mem_write;
        end
      end
      BUSY: begin
        err_d = mem_read || mem_write;
        if (complete) begin
          state_d = IDLE;
          if (op_q == OP_READ) begin
            hold_d = ram_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is shown straight from the RAM in the completion cycle and
  // held in a register afterwards.
  assign mem_data_out = (complete && (op_q == OP_READ)) ? ram_q : hold_q;
  assign mem_ready    = complete;
  assign mem_busy     = (state_q == BUSY);
  assign protocol_err = err_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: LATENCY=4 and LATENCY=1 instances share
// stimulus and are checked every cycle against a request-level model.
module tb_main_memory_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int LIMIT = 5000;
  localparam int F_READY = 0;
  localparam int F_BUSY  = 1;
  localparam int F_ERR   = 2;
  localparam int F_DOUT  = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic [31:0] dout  [2];
  logic        ready [2];
  logic        busy  [2];
  logic        err   [2];

  int cyc = 0;
  bit done = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  main_memory_responder #(.DEPTH(DEPTH), .LATENCY(4), .WORD_SIZE(32)) u_lat4 (
    .clk(clk), .reset_n(reset_n), .mem_address(addr), .mem_data_in(wdata),
    .mem_read(rd), .mem_write(wr), .mem_data_out(dout[0]), .mem_ready(ready[0]),
    .mem_busy(busy[0]), .protocol_err(err[0])
  );

  main_memory_responder #(.DEPTH(DEPTH), .LATENCY(1), .WORD_SIZE(32)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .mem_address(addr), .mem_data_in(wdata),
    .mem_read(rd), .mem_write(wr), .mem_data_out(dout[1]), .mem_ready(ready[1]),
    .mem_busy(busy[1]), .protocol_err(err[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed expectations pinned to absolute cycles.
  typedef struct {
    int          c;
    int          k;
    int          f;
    logic [31:0] v;
  } pin_t;
  pin_t pins[$];

  task automatic pin(input int c, input int k, input int f, input logic [31:0] v);
    pins.push_back('{c, k, f, v});
  endtask

  // Request-level model: one request in flight, done LATENCY cycles after accept.
  bit          m_busy [2];
  int          m_done [2];
  int          m_idx  [2];
  logic [31:0] m_dat  [2];
  bit          m_wr   [2];
  bit          m_err  [2];
  logic [31:0] m_hold [2];
  bit          m_hk   [2];
  logic [31:0] m_mem  [int];

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [31:0] field_of(input int k, input int f);
    case (f)
      F_READY: return {31'd0, ready[k]};
      F_BUSY:  return {31'd0, busy[k]};
      F_ERR:   return {31'd0, err[k]};
      default: return dout[k];
    endcase
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit          e_rdy;
      bit          known;
      bit          nerr;
      logic [31:0] e_dout;
      int          key;
      if (!reset_n) begin
        m_busy[k] = 1'b0; m_err[k] = 1'b0; m_hold[k] = '0; m_hk[k] = 1'b1;
        chk("reset_ready", k, {31'd0, ready[k]}, 32'd0);
        chk("reset_busy",  k, {31'd0, busy[k]},  32'd0);
        chk("reset_err",   k, {31'd0, err[k]},   32'd0);
        chk("reset_dout",  k, dout[k],           32'd0);
      end else begin
        e_rdy = m_busy[k] && (cyc == m_done[k]);
        key   = k * 4096 + m_idx[k];
        if (e_rdy && !m_wr[k]) begin
          known  = m_mem.exists(key);
          e_dout = known ? m_mem[key] : '0;
        end else begin
          known  = m_hk[k];
          e_dout = m_hold[k];
        end
        chk("ready", k, {31'd0, ready[k]}, {31'd0, e_rdy});
        chk("busy",  k, {31'd0, busy[k]},  {31'd0, m_busy[k]});
        chk("err",   k, {31'd0, err[k]},   {31'd0, m_err[k]});
        if (known) chk("dout", k, dout[k], e_dout);
        nerr = m_busy[k] ? (rd || wr) : (rd && wr);
        if (m_busy[k]) begin
          if (e_rdy) begin
            if (m_wr[k]) m_mem[key] = m_dat[k];
            else begin
              m_hk[k] = known;
              m_hold[k] = e_dout;
            end
            m_busy[k] = 1'b0;
          end
        end else if (rd || wr) begin
          m_busy[k] = 1'b1;
          m_done[k] = cyc + lat_of(k);
          m_idx[k]  = int'((addr >> 2) % DEPTH);
          m_dat[k]  = wdata;
          m_wr[k]   = wr;
        end
        m_err[k] = nerr;
      end
    end
    for (int i = pins.size() - 1; i >= 0; i--) begin
      if (pins[i].c == cyc) begin
        chk("pinned", pins[i].k, field_of(pins[i].k, pins[i].f), pins[i].v);
        pins.delete(i);
      end
    end
    if (done || cyc > LIMIT) begin
      chk("pins_left", 0, pins.size(), 0);
      chk("timeout", 0, {31'd0, (cyc > LIMIT)}, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    step();
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int T;
    int r;
    reset_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    idle(3);
    pin(cyc, 0, F_DOUT, 32'd0);
    pin(cyc, 0, F_BUSY, 32'd0);
    reset_n = 1'b1;
    step();

    // write then read back, mem_ready at T+4 / T+1
    T = cyc;
    pin(T+1, 0, F_BUSY, 1); pin(T+4, 0, F_BUSY, 1); pin(T+5, 0, F_BUSY, 0);
    pin(T+3, 0, F_READY, 0); pin(T+4, 0, F_READY, 1); pin(T+5, 0, F_READY, 0);
    pin(T+1, 1, F_READY, 1);
    issue(0, 1, 32'h0000_0040, 32'hDEAD_BEEF); idle(4);
    T = cyc;
    pin(T+4, 0, F_READY, 1); pin(T+4, 0, F_DOUT, 32'hDEAD_BEEF);
    pin(T+1, 1, F_DOUT, 32'hDEAD_BEEF);
    issue(1, 0, 32'h0000_0040, 32'h0); idle(4);

    // aliasing and byte offset
    issue(0, 1, 32'h0000_0004, 32'h1111_1111); idle(4);
    T = cyc;
    pin(T+4, 0, F_DOUT, 32'h1111_1111); pin(T+1, 1, F_DOUT, 32'h1111_1111);
    issue(1, 0, 32'h0000_1007, 32'h0); idle(4);

    // simultaneous strobes: write wins, error pulse, dout untouched
    T = cyc;
    pin(T+1, 0, F_ERR, 1); pin(T+2, 0, F_ERR, 0); pin(T+1, 1, F_ERR, 1);
    pin(T+4, 0, F_READY, 1); pin(T+4, 0, F_DOUT, 32'h1111_1111);
    issue(1, 1, 32'h0000_0080, 32'hA5A5_A5A5); idle(4);
    T = cyc;
    pin(T+4, 0, F_DOUT, 32'hA5A5_A5A5); pin(T+1, 1, F_DOUT, 32'hA5A5_A5A5);
    issue(1, 0, 32'h0000_0080, 32'h0); idle(4);

    // strobe while busy is ignored by the LATENCY=4 instance
    T = cyc;
    pin(T+2, 0, F_ERR, 0); pin(T+3, 0, F_ERR, 1);
    pin(T+3, 0, F_READY, 0); pin(T+4, 0, F_READY, 1); pin(T+5, 0, F_READY, 0);
    issue(0, 1, 32'h0000_0080, 32'h3C3C_3C3C);
    step();
    issue(0, 1, 32'h0000_0080, 32'h2222_2222);
    idle(2);
    T = cyc;
    pin(T+4, 0, F_DOUT, 32'h3C3C_3C3C); pin(T+1, 1, F_DOUT, 32'h2222_2222);
    issue(1, 0, 32'h0000_0080, 32'h0); idle(4);

    // reset in the middle of a read
    T = cyc;
    issue(1, 0, 32'h0000_0040, 32'h0);
    step();
    reset_n = 1'b0;
    pin(T+2, 0, F_BUSY, 0); pin(T+2, 0, F_READY, 0); pin(T+2, 0, F_DOUT, 0);
    pin(T+4, 0, F_READY, 0);
    idle(2);
    reset_n = 1'b1;
    step();
    T = cyc;
    pin(T+4, 0, F_DOUT, 32'hDEAD_BEEF); pin(T+1, 1, F_DOUT, 32'hDEAD_BEEF);
    issue(1, 0, 32'h0000_0040, 32'h0); idle(4);

    // held strobes: LATENCY=1 completes every second cycle
    for (int i = 0; i < 4; i++) begin
      T = cyc;
      pin(T+1, 1, F_READY, 1); pin(T+2, 1, F_READY, 0);
      wr = 1'b1; addr = 32'h200 + 32'(4 * i); wdata = 32'h5000_0000 + 32'(i);
      idle(2);
    end
    wr = 1'b0; idle(8);
    for (int i = 0; i < 4; i++) begin
      T = cyc;
      pin(T+1, 1, F_DOUT, 32'h5000_0000 + 32'(i));
      rd = 1'b1; addr = 32'h200 + 32'(4 * i);
      idle(2);
    end
    rd = 1'b0; idle(8);

    // random traffic over a small aliased window
    for (int n = 0; n < 700; n++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      r = $urandom_range(0, 9);
      rd = (r <= 2) || (r == 6);
      wr = (r >= 3 && r <= 6);
      addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wdata = $urandom;
      step();
    end
    rd = 1'b0; wr = 1'b0; reset_n = 1'b1;
    idle(8);
    done = 1'b1;
  end

endmodule
